// File: rtl/regfile_2r1w_pkg.sv
// Shared constants for the general-purpose register file of the five-stage core.
package regfile_2r1w_pkg;

  // Register file geometry
  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;
  localparam int unsigned RegNumLog2 = 5;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Control encodings; reset is active-low in this core revision
  localparam logic WriteEnable = 1'b1;
  localparam logic ReadEnable  = 1'b1;
  localparam logic RstEnable   = 1'b0;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Decode/write-back side of the register file: one write port, two read ports.
interface regfile_2r1w_if
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
);

  // Write port (from write-back)
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Read port 1 (decode operand 1)
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;

  // Read port 2 (decode operand 2)
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;

  // Requester side: pipeline stages
  modport master (
    output we, waddr, wdata,
    output re1, raddr1,
    output re2, raddr2,
    input  rdata1, rdata2
  );

  // Responder side: the register file
  modport slave (
    input  we, waddr, wdata,
    input  re1, raddr1,
    input  re2, raddr2,
    output rdata1, rdata2
  );

endinterface

// File: rtl/regfile_2r1w_rdport.sv
// One combinational read port: reset, zero register, write-through bypass, array, disabled.
module regfile_2r1w_rdport
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] reg_data,
  output logic [DATA_W-1:0] rdata
);

  logic bypass_hit;

  // A pending write to the same register is forwarded so decode sees it this cycle
  assign bypass_hit = (re == ReadEnable) && (we == WriteEnable) && (waddr == raddr);

  // Priority mux; $0 wins over the bypass so a discarded write to r0 never leaks out
  always_comb begin
    rdata = '0;
    if (rst == RstEnable) begin
      rdata = '0;
    end else if (raddr == '0) begin
      rdata = '0;
    end else if (bypass_hit) begin
      rdata = wdata;
    end else if (re == ReadEnable) begin
      rdata = reg_data;
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// 2-read / 1-write general-purpose register file with async clear and write-through bypass.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned NREG   = RegNum
) (
  input  logic          clk,
  input  logic          rst,
  regfile_2r1w_if.slave bus
);

  // Flops rather than RAM: the whole array must clear asynchronously
  logic [DATA_W-1:0] regs [NREG];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;

  assign we    = bus.we;
  assign waddr = bus.waddr;
  assign wdata = bus.wdata;

  // Writes to $0 are dropped, so regs[0] is never loaded after reset
  assign wr_en = (we == WriteEnable) && (waddr != '0);

  // Storage: async clear of every entry, otherwise single-port write on the rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[waddr] <= wdata;
    end
  end

  logic [DATA_W-1:0] rd_reg1;
  logic [DATA_W-1:0] rd_reg2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  assign rd_reg1 = regs[bus.raddr1];
  assign rd_reg2 = regs[bus.raddr2];

  regfile_2r1w_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport1 (
    .rst      (rst),
    .re       (bus.re1),
    .raddr    (bus.raddr1),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .reg_data (rd_reg1),
    .rdata    (rdata1)
  );

  regfile_2r1w_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rdport2 (
    .rst      (rst),
    .re       (bus.re2),
    .raddr    (bus.raddr2),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .reg_data (rd_reg2),
    .rdata    (rdata2)
  );

  assign bus.rdata1 = rdata1;
  assign bus.rdata2 = rdata2;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed-vector bench for regfile_2r1w.
module tb_regfile_2r1w;

  logic clk;
  logic rst;

  int vectors;
  int miscompares;

  regfile_2r1w_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_2r1w #(
    .DATA_W (32),
    .ADDR_W (5),
    .NREG   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    bus.we    = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    tick();
    bus.we    = 1'b0;
  endtask

  task automatic test_reset();
    bus.re1 = 1'b1; bus.raddr1 = 5'd1;
    bus.re2 = 1'b1; bus.raddr2 = 5'd2;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hold_rd1: got %h required %h", bus.rdata1, 32'h0);
    end
    vectors++;
    if (bus.rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hold_rd2: got %h required %h", bus.rdata2, 32'h0);
    end
    tick();
    rst = 1'b1;
    tick();
    // Load r7, confirm, then pulse reset mid-cycle
    do_write(5'd7, 32'hDEAD_BEEF);
    bus.raddr1 = 5'd7;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL r7_loaded: got %h required %h", bus.rdata1, 32'hDEAD_BEEF);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_immediate: got %h required %h", bus.rdata1, 32'h0);
    end
    #1;
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL r7_after_reset: got %h required %h", bus.rdata1, 32'h0);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'h1234_5678);
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wr_rd_port1: got %h required %h", bus.rdata1, 32'h1234_5678);
    end
    vectors++;
    if (bus.rdata2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL wr_rd_port2: got %h required %h", bus.rdata2, 32'h1234_5678);
    end
  endtask

  task automatic test_bypass();
    do_write(5'd9, 32'h0000_0001);
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'hA5A5_A5A5;
    bus.re2 = 1'b1; bus.raddr2 = 5'd9;
    bus.re1 = 1'b0; bus.raddr1 = 5'd9;
    #1;
    vectors++;
    if (bus.rdata2 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_rd2: got %h required %h", bus.rdata2, 32'hA5A5_A5A5);
    end
    // Disabled port must not pick up the bypass
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_disabled_rd1: got %h required %h", bus.rdata1, 32'h0);
    end
    bus.re1 = 1'b1;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_both_rd1: got %h required %h", bus.rdata1, 32'hA5A5_A5A5);
    end
    tick();
    bus.we = 1'b0;
    #1;
    vectors++;
    if (bus.rdata2 !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL bypass_stored_rd2: got %h required %h", bus.rdata2, 32'hA5A5_A5A5);
    end
  endtask

  task automatic test_zero_reg();
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFF_FFFF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd0;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_wcyc_rd1: got %h required %h", bus.rdata1, 32'h0);
    end
    vectors++;
    if (bus.rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_wcyc_rd2: got %h required %h", bus.rdata2, 32'h0);
    end
    tick();
    bus.we = 1'b0;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_next_rd1: got %h required %h", bus.rdata1, 32'h0);
    end
    vectors++;
    if (bus.rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_next_rd2: got %h required %h", bus.rdata2, 32'h0);
    end
  endtask

  task automatic test_read_disable();
    do_write(5'd3, 32'h0000_0042);
    bus.re1 = 1'b0; bus.raddr1 = 5'd3;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rd_disabled: got %h required %h", bus.rdata1, 32'h0);
    end
    bus.re1 = 1'b1;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0000_0042) begin
      miscompares++;
      $display("FAIL rd_enabled: got %h required %h", bus.rdata1, 32'h0000_0042);
    end
  endtask

  task automatic test_back_to_back();
    do_write(5'd10, 32'h0000_0001);
    // Second write to the same register: bypass first, then storage
    bus.we = 1'b1; bus.waddr = 5'd10; bus.wdata = 32'h0000_0002;
    bus.re1 = 1'b1; bus.raddr1 = 5'd10;
    bus.re2 = 1'b1; bus.raddr2 = 5'd5;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL b2b_bypass: got %h required %h", bus.rdata1, 32'h0000_0002);
    end
    vectors++;
    if (bus.rdata2 !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL b2b_other_port: got %h required %h", bus.rdata2, 32'h1234_5678);
    end
    tick();
    bus.we = 1'b0;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL b2b_last_wins: got %h required %h", bus.rdata1, 32'h0000_0002);
    end
    do_write(5'd31, 32'h8000_0001);
    bus.raddr2 = 5'd31;
    #1;
    vectors++;
    if (bus.rdata2 !== 32'h8000_0001) begin
      miscompares++;
      $display("FAIL top_reg_r31: got %h required %h", bus.rdata2, 32'h8000_0001);
    end
  endtask

  task automatic test_reset_mid_write();
    do_write(5'd4, 32'h0000_0055);
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 32'h0000_0077;
    bus.re1 = 1'b1; bus.raddr1 = 5'd4;
    #3;
    rst = 1'b0;
    tick();
    bus.we = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_write_release: got %h required %h", bus.rdata1, 32'h0);
    end
    tick();
    vectors++;
    if (bus.rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_write_later: got %h required %h", bus.rdata1, 32'h0);
    end
    // First edge after release performs a write normally
    do_write(5'd4, 32'h0000_0099);
    vectors++;
    if (bus.rdata1 !== 32'h0000_0099) begin
      miscompares++;
      $display("FAIL post_reset_write: got %h required %h", bus.rdata1, 32'h0000_0099);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    bus.we      = 1'b0;
    bus.waddr   = '0;
    bus.wdata   = '0;
    bus.re1     = 1'b0;
    bus.raddr1  = '0;
    bus.re2     = 1'b0;
    bus.raddr2  = '0;

    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_read_disable();
    test_back_to_back();
    test_reset_mid_write();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

General-purpose register file for the five-stage MIPS core: 32 × 32-bit registers, one synchronous write port driven by the write-back stage, and two combinational read ports serving the decode stage's operand requests. It is the responder for the decode stage's read-enable/read-address interface and returns operand data in the same cycle. A write-through bypass returns a value being written this cycle to a same-cycle read. Register `$0` reads as zero and ignores writes.

## Interface
Parameters:
- `DATA_W`, 32, register width (`RegBus`)
- `ADDR_W`, 5, register address width (`RegAddrBus`)
- `NREG`, 32, number of registers (`RegNum`); must equal 2**`ADDR_W`

Ports:
- `clk`  in  1  core clock; all register updates occur on the rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `we`  in  1  write enable from write-back (`WriteEnable` = 1)
- `waddr`  in  `ADDR_W`  destination register
- `wdata`  in  `DATA_W`  write data
- `re1`  in  1  read-port-1 enable (`ReadEnable` = 1), from decode `reg1_read_o`
- `raddr1`  in  `ADDR_W`  read-port-1 address, from decode `reg1_addr_o`
- `rdata1`  out  `DATA_W`  read-port-1 data, to decode `reg1_data_i`
- `re2`  in  1  read-port-2 enable
- `raddr2`  in  `ADDR_W`  read-port-2 address
- `rdata2`  out  `DATA_W`  read-port-2 data

## Operation
- Storage is an array `regs[0..NREG-1]` of `DATA_W` bits.
- Reset (`rst` = 0, asynchronous): every entry clears to `ZeroWord` immediately, regardless of `clk`. While reset is held, `rdata1` and `rdata2` are forced to `ZeroWord`.
- Write: on a `clk` rising edge with `rst` = 1, `we` = 1 and `waddr` ≠ 0, `regs[waddr]` <= `wdata`. A write to address 0 is discarded, so `regs[0]` stays 0 permanently.
- Read port k (k = 1, 2) is purely combinational and resolves in this priority order:
  1. `rst` = 0 → 0
  2. `raddrk` = 0 → 0, even when a write to 0 is pending
  3. `rek` = 1 and `we` = 1 and `waddr` = `raddrk` → `wdata` (write-through bypass)
  4. `rek` = 1 → `regs[raddrk]`
  5. `rek` = 0 → 0
- The two read ports are independent. Both may address the same register, and both may hit the bypass in the same cycle.
- No width conversion is done; all data paths are `DATA_W` bits.

## Timing
- Read latency is 0 cycles: the read port is combinational from `raddr`/`re`, and from `we`/`waddr`/`wdata` through the bypass.
- Write latency is 1 edge. The value is visible through the bypass during the write cycle, and from storage from the next cycle onward.
- Reset assertion takes effect on all outputs and storage without waiting for `clk`.
- Reset deassertion takes effect at the first rising edge after `rst` rises; that edge may perform a write.
- Reset asserted mid-write: a write whose edge coincides with `rst` = 0 is lost, and the register stays 0.
- Back-to-back writes to the same address: the last edge wins. Reads between edges see the current bypass or stored value.
- Combinational paths (decode → register file → decode) must not form a loop; no output of this block feeds its own inputs.

## Structure
- Shared constants belong in `defines.v`: `RegBus`, `RegAddrBus`, `RegNum`, `RegNumLog2`, `ZeroWord`, `WriteEnable`, `ReadEnable`, `RstEnable`.
  - `RstEnable` must be redefined to 1'b0 for this core revision, because reset is now active-low.
- One sub-module is natural: `regfile_rdport`. It contains the read-port priority mux (reset, zero-register, bypass, array, disabled) and is instantiated twice. The array and write logic stay in the top level.
- The array is implemented as flops, not inferred RAM, because of the asynchronous whole-array clear.

## Test plan
- Reset clear:
  - Write r7 = 0xDEADBEEF, then pulse `rst` = 0 mid-cycle.
  - Required: `rdata1` = 0 immediately; after release, reading r7 with `re1` = 1 returns 0x00000000.
- Basic write/read:
  - Write r5 = 0x12345678 at edge N.
  - Required: at cycle N+1, `raddr1` = 5 and `re1` = 1 give 0x12345678, and `raddr2` = 5 and `re2` = 1 give the same value.
- Same-cycle bypass:
  - In one cycle, set `we` = 1, `waddr` = 9, `wdata` = 0xA5A5A5A5, `raddr2` = 9, `re2` = 1, with r9 previously 0x1.
  - Required: `rdata2` = 0xA5A5A5A5 in that cycle and after the edge.
- Zero register:
  - Write 0xFFFFFFFF to r0 while reading r0 on both ports.
  - Required: both ports return 0 during the write cycle and the following cycle.
- Read disable:
  - Load r3 = 0x00000042, then read it with `re1` = 0 and `raddr1` = 3.
  - Required: `rdata1` = 0; with `re1` = 1, `rdata1` = 0x00000042.
- Reset mid-write:
  - Assert `rst` = 0 coincident with an edge that has `we` = 1, `waddr` = 4, `wdata` = 0x77.
  - Required: r4 reads 0 after reset releases.
